a5_1_keystream_gen: RTL and testbench
=====================================

// Module: a5_1_keystream_gen
// PURPOSE
//  A5/1 keystream generator: three internal LFSRs (19/22/23 bits), majority clocking and the
//  session sequencer (clear, 64-bit key load, 22-bit frame load, warm-up, streaming).
//  Sits between the host register block (key/frame/start) and the XOR cipher datapath,
//  which consumes one keystream bit per valid/ready handshake.
// PARAMETERS
//  WARMUP_CYCLES   100  majority clocks discarded after frame load (GSM value 100)
//  KEYSTREAM_BITS  228  keystream bits produced per session (>=1)
// PORTS
//  clk        in   1   clock
//  reset_n    in   1   asynchronous, active-low reset
//  start      in   1   1-cycle pulse; begins a session; ignored unless busy==0
//  abort      in   1   synchronous; returns to IDLE next cycle, drops ks_valid
//  key        in   64  session key; key[0] loaded first (key[8j+b] = byte j bit b)
//  frame      in   22  frame number; frame[0] loaded first
//  ks_bit     out  1   keystream bit (R1[18]^R2[21]^R3[22])
//  ks_valid   out  1   ks_bit valid
//  ks_ready   in   1   consumer accepts ks_bit when ks_valid&&ks_ready
//  busy       out  1   high from cycle after accepted start until return to IDLE
//  done       out  1   1-cycle pulse after last keystream bit accepted
// BEHAVIOUR
//  - Reset: state=IDLE, R1/R2/R3=0, counters=0; ks_valid=0, busy=0, done=0, ks_bit=0.
//  - Registers: shift toward MSB, new bit at [0] = feedback ^ din.
//    R1 taps 13,16,17,18 clk bit 8; R2 taps 20,21 clk bit 10; R3 taps 7,20,21,22 clk bit 10.
//  - Majority clock: m = maj(R1[8],R2[10],R3[10]); register i shifts iff its clk bit == m
//    (always >=2 registers shift); din=0.
//  - start in IDLE: latch key/frame, go CLEAR. start outside IDLE: no effect.
//  - CLEAR (1 cycle): R1/R2/R3 <= 0.
//  - KEY (64 cycles): all three shift every cycle, din = key[n], n=0..63.
//  - FRAME (22 cycles): all three shift every cycle, din = frame[n], n=0..21.
//  - WARMUP (WARMUP_CYCLES+1 cycles): one majority clock per cycle, output discarded;
//    the extra clock primes the first keystream bit.
//  - STREAM: ks_valid=1, ks_bit = XOR of MSBs (from registers; stable while stalled).
//    On handshake: one majority clock, count++. Without ready: no register change.
//    Handshake on bit KEYSTREAM_BITS-1: ks_valid=0 next cycle, done=1 for 1 cycle, IDLE.
//  - Total latency start->first ks_valid: 1+1+64+22+WARMUP_CYCLES+1 = 189 cycles (defaults).
//  - abort in any state: next cycle IDLE, ks_valid=0, busy=0, done=0; registers keep value.
//    abort and start same cycle in IDLE: abort wins (start dropped).
//  - Counters sized for max(64, WARMUP_CYCLES+1, KEYSTREAM_BITS); no wrap inside a state.
//  - Async reset mid-session: immediate return to reset values; no done pulse.
//  - After done, key/frame may change; next start uses newly latched values.
// TESTING
//  1 GSM vector: key=64'hEFCDAB8967452312, frame=22'h134, ready=1 -> first 8 bits
//    0,1,0,1,0,0,1,1 (0x53 MSB-first), full 114 bits = 534EAA582FE8151AB6E1855A728C00 (pad).
//  2 Latency: start at cycle 0 -> ks_valid first high at cycle 189; busy high cycles 1..end.
//  3 Backpressure: ready toggled randomly -> ks_bit stable while valid&&!ready, stream
//    identical to test 1; done exactly one cycle after 228th handshake.
//  4 start while busy (cycles 10, 150, 300) -> ignored, stream unchanged.
//  5 abort at cycle 100 then start with test-1 vector -> correct stream from scratch.
//  6 reset_n low in STREAM -> ks_valid/busy/done 0 same cycle; next session correct.

Source files
------------

// File: rtl/a5_1_keystream_gen.sv
// A5/1 keystream generator: three majority-clocked LFSRs plus the session sequencer
// (clear, key load, frame load, warm-up, handshaked keystream streaming).
module a5_1_keystream_gen #(
  parameter int unsigned WARMUP_CYCLES  = 100,
  parameter int unsigned KEYSTREAM_BITS = 228
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic        ks_bit,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MAX_KW  = (WARMUP_CYCLES + 1 > 64) ? WARMUP_CYCLES + 1 : 64;
  localparam int unsigned CNT_MAX = (KEYSTREAM_BITS > MAX_KW) ? KEYSTREAM_BITS : MAX_KW;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(63);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(21);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KEYSTREAM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_KEY,
    S_FRAME,
    S_WARMUP,
    S_STREAM
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [18:0]       r1, r1_next;
  logic [21:0]       r2, r2_next;
  logic [22:0]       r3, r3_next;
  logic [63:0]       key_sr, key_next;
  logic [21:0]       frame_sr, frame_next;
  logic              done_q, done_next;

  logic              fb1, fb2, fb3;
  logic              maj;
  logic              clk1, clk2, clk3;
  logic [18:0]       r1_shift;
  logic [21:0]       r2_shift;
  logic [22:0]       r3_shift;

  assign fb1 = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
  assign fb2 = r2[20] ^ r2[21];
  assign fb3 = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];

  assign r1_shift = {r1[17:0], fb1};
  assign r2_shift = {r2[20:0], fb2};
  assign r3_shift = {r3[21:0], fb3};

  // Registers whose clocking bit agrees with the majority step; at least two always do.
  assign maj  = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
  assign clk1 = (r1[8]  == maj);
  assign clk2 = (r2[10] == maj);
  assign clk3 = (r3[10] == maj);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    r1_next    = r1;
    r2_next    = r2;
    r3_next    = r3;
    key_next   = key_sr;
    frame_next = frame_sr;
    done_next  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_CLEAR;
          key_next   = key;
          frame_next = frame;
          cnt_next   = '0;
        end
      end

      S_CLEAR: begin
        r1_next    = '0;
        r2_next    = '0;
        r3_next    = '0;
        cnt_next   = '0;
        state_next = S_KEY;
      end

      S_KEY: begin
        r1_next  = r1_shift ^ {{18{1'b0}}, key_sr[0]};
        r2_next  = r2_shift ^ {{21{1'b0}}, key_sr[0]};
        r3_next  = r3_shift ^ {{22{1'b0}}, key_sr[0]};
        key_next = {1'b0, key_sr[63:1]};
        if (cnt == KEY_LAST) begin
          cnt_next   = '0;
          state_next = S_FRAME;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      S_FRAME: begin
        r1_next    = r1_shift ^ {{18{1'b0}}, frame_sr[0]};
        r2_next    = r2_shift ^ {{21{1'b0}}, frame_sr[0]};
        r3_next    = r3_shift ^ {{22{1'b0}}, frame_sr[0]};
        frame_next = {1'b0, frame_sr[21:1]};
        if (cnt == FRAME_LAST) begin
          cnt_next   = '0;
          state_next = S_WARMUP;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      S_WARMUP: begin
        r1_next = clk1 ? r1_shift : r1;
        r2_next = clk2 ? r2_shift : r2;
        r3_next = clk3 ? r3_shift : r3;
        if (cnt == WARM_LAST) begin
          cnt_next   = '0;
          state_next = S_STREAM;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      S_STREAM: begin
        if (ks_ready) begin
          r1_next = clk1 ? r1_shift : r1;
          r2_next = clk2 ? r2_shift : r2;
          r3_next = clk3 ? r3_shift : r3;
          if (cnt == KS_LAST) begin
            cnt_next   = '0;
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Abort overrides everything, including a start or a final handshake in the same cycle.
    if (abort) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      r1_next    = r1;
      r2_next    = r2;
      r3_next    = r3;
      key_next   = key_sr;
      frame_next = frame_sr;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      key_sr   <= '0;
      frame_sr <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      r1       <= r1_next;
      r2       <= r2_next;
      r3       <= r3_next;
      key_sr   <= key_next;
      frame_sr <= frame_next;
      done_q   <= done_next;
    end
  end

  assign ks_valid = (state == S_STREAM);
  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign ks_bit   = ks_valid & (r1[18] ^ r2[21] ^ r3[22]);

endmodule

// File: tb/tb_a5_1_keystream_gen.sv
// Bench for a5_1_keystream_gen: random and GSM-vector sessions checked against a
// bit-level A5/1 reference built from tap masks and majority voting.
module tb_a5_1_keystream_gen;

  localparam int unsigned WARM = 100;
  localparam int unsigned KSB  = 228;
  localparam int LAT = 1 + 1 + 64 + 22 + WARM + 1;

  localparam logic [63:0]  GSM_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0]  GSM_FRAME = 22'h134;
  localparam logic [119:0] GSM_AB    = 120'h534EAA582FE8151AB6E1855A728C00;

  localparam int unsigned LEN[3]  = '{19, 22, 23};
  localparam int unsigned CBIT[3] = '{8, 10, 10};
  localparam int unsigned TAP[3]  = '{(1 << 13) | (1 << 16) | (1 << 17) | (1 << 18),
                                      (1 << 20) | (1 << 21),
                                      (1 << 7) | (1 << 20) | (1 << 21) | (1 << 22)};

  logic        clk = 1'b0;
  logic        reset_n, start, abort, ks_ready;
  logic [63:0] key;
  logic [21:0] frame;
  logic        ks_bit, ks_valid, busy, done;

  a5_1_keystream_gen #(.WARMUP_CYCLES(WARM), .KEYSTREAM_BITS(KSB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .key(key), .frame(frame), .ks_bit(ks_bit), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total, bad;

  logic        exp_bits[KSB];
  logic        got_bits[KSB];
  int unsigned mr[3];
  int          got_n, first_valid, last_hs, done_cyc, done_count;
  int          busy_err, stall_err, late_err;
  bit          timed_out;

  function automatic int unsigned bit_of(input int unsigned r, input int unsigned n);
    return (r >> n) & 32'd1;
  endfunction

  function automatic int unsigned lfsr_step(input int unsigned r, input int unsigned len,
                                            input int unsigned taps, input int unsigned din);
    int unsigned fb;
    fb = 32'($countones(r & taps)) & 32'd1;
    return ((r << 1) | (fb ^ din)) & ((32'd1 << len) - 32'd1);
  endfunction

  task automatic maj_clock();
    int unsigned votes;
    int unsigned m;
    votes = bit_of(mr[0], CBIT[0]) + bit_of(mr[1], CBIT[1]) + bit_of(mr[2], CBIT[2]);
    m = (votes >= 2) ? 32'd1 : 32'd0;
    for (int j = 0; j < 3; j++)
      if (bit_of(mr[j], CBIT[j]) == m) mr[j] = lfsr_step(mr[j], LEN[j], TAP[j], 0);
  endtask

  task automatic model_stream(input logic [63:0] k, input logic [21:0] f);
    mr = '{0, 0, 0};
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 3; j++) mr[j] = lfsr_step(mr[j], LEN[j], TAP[j], 32'(k[i]));
    for (int i = 0; i < 22; i++)
      for (int j = 0; j < 3; j++) mr[j] = lfsr_step(mr[j], LEN[j], TAP[j], 32'(f[i]));
    for (int i = 0; i < int'(WARM) + 1; i++) maj_clock();
    for (int i = 0; i < int'(KSB); i++) begin
      exp_bits[i] = 1'((bit_of(mr[0], 18) ^ bit_of(mr[1], 21) ^ bit_of(mr[2], 22)));
      maj_clock();
    end
  endtask

  // Pulses start in cycle 0 and returns #1 into cycle 1.
  task automatic start_session(input logic [63:0] k, input logic [21:0] f);
    key   = k;
    frame = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records one session's observable timing and stream; comparisons live in each test.
  task automatic collect(input bit rnd_ready, input bit poke);
    int  cyc;
    bit  hold;
    logic hold_bit;
    got_n = 0; first_valid = -1; last_hs = -1; done_cyc = -1; done_count = 0;
    busy_err = 0; stall_err = 0; late_err = 0; timed_out = 0;
    hold = 0; hold_bit = 1'b0; cyc = 1;
    forever begin
      if (done === 1'b1) begin
        done_count++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (last_hs < 0 && busy !== 1'b1) busy_err++;
      if (hold && (ks_valid !== 1'b1 || ks_bit !== hold_bit)) stall_err++;
      hold  = 0;
      start = 1'b0;
      if (poke && (cyc == 10 || cyc == 150 || cyc == 300)) begin
        start = 1'b1;
        key   = ~key;
        frame = ~frame;
      end
      if (ks_valid === 1'b1 && got_n < int'(KSB)) begin
        if (first_valid < 0) first_valid = cyc;
        ks_ready = rnd_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
        if (ks_ready) begin
          got_bits[got_n] = ks_bit;
          got_n++;
          if (got_n == int'(KSB)) last_hs = cyc;
        end else begin
          hold = 1;
          hold_bit = ks_bit;
        end
      end else begin
        ks_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (last_hs >= 0 && cyc == last_hs + 1 && (ks_valid !== 1'b0 || busy !== 1'b0)) late_err++;
      if (last_hs >= 0 && cyc == last_hs + 3) break;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    ks_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ks_valid, busy, done, ks_bit} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000", {ks_valid, busy, done, ks_bit});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ks_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b want 000", {ks_valid, busy, done});
    end
  endtask

  task automatic test_gsm_vector();
    logic [119:0] ab;
    ab = GSM_AB;
    model_stream(GSM_KEY, GSM_FRAME);
    start_session(GSM_KEY, GSM_FRAME);
    collect(0, 0);
    total++;
    if (timed_out || got_n != int'(KSB)) begin
      bad++; $display("FAIL gsm_count: got %0d bits want %0d", got_n, KSB);
    end
    total++;
    if (first_valid != LAT) begin
      bad++; $display("FAIL gsm_latency: got %0d want %0d", first_valid, LAT);
    end
    for (int i = 0; i < 114 && i < got_n; i++) begin
      total++;
      if (got_bits[i] !== ab[119 - i]) begin
        bad++; $display("FAIL gsm_vector_bit%0d: got %b want %b", i, got_bits[i], ab[119 - i]);
      end
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_bits[i] !== exp_bits[i]) begin
        bad++; $display("FAIL gsm_model_bit%0d: got %b want %b", i, got_bits[i], exp_bits[i]);
      end
    end
    total++;
    if (busy_err != 0) begin
      bad++; $display("FAIL gsm_busy: got %0d low cycles want 0", busy_err);
    end
    total++;
    if (done_count != 1 || done_cyc != last_hs + 1) begin
      bad++; $display("FAIL gsm_done: got count %0d at %0d want 1 at %0d", done_count, done_cyc, last_hs + 1);
    end
    total++;
    if (late_err != 0 || last_hs != LAT + int'(KSB) - 1) begin
      bad++; $display("FAIL gsm_end: got last %0d late %0d want %0d/0", last_hs, late_err, LAT + int'(KSB) - 1);
    end
  endtask

  task automatic test_backpressure();
    model_stream(GSM_KEY, GSM_FRAME);
    start_session(GSM_KEY, GSM_FRAME);
    collect(1, 0);
    total++;
    if (timed_out || got_n != int'(KSB)) begin
      bad++; $display("FAIL bp_count: got %0d want %0d", got_n, KSB);
    end
    total++;
    if (stall_err != 0) begin
      bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err);
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_bits[i] !== exp_bits[i]) begin
        bad++; $display("FAIL bp_bit%0d: got %b want %b", i, got_bits[i], exp_bits[i]);
      end
    end
    total++;
    if (done_count != 1 || done_cyc != last_hs + 1 || late_err != 0) begin
      bad++; $display("FAIL bp_done: got count %0d at %0d want 1 at %0d", done_count, done_cyc, last_hs + 1);
    end
  endtask

  task automatic test_start_while_busy();
    model_stream(GSM_KEY, GSM_FRAME);
    start_session(GSM_KEY, GSM_FRAME);
    collect(0, 1);
    total++;
    if (first_valid != LAT || got_n != int'(KSB)) begin
      bad++; $display("FAIL busy_start_timing: got lat %0d n %0d want %0d/%0d", first_valid, got_n, LAT, KSB);
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_bits[i] !== exp_bits[i]) begin
        bad++; $display("FAIL busy_start_bit%0d: got %b want %b", i, got_bits[i], exp_bits[i]);
      end
    end
  endtask

  task automatic test_abort();
    start_session({$urandom, $urandom}, 22'($urandom));
    repeat (99) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL abort_prebusy: got %b want 1", busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ks_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL abort_idle: got %b want 000", {ks_valid, busy, done});
    end
    start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_wins: got busy %b want 0", busy);
    end
    abort = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    model_stream(GSM_KEY, GSM_FRAME);
    start_session(GSM_KEY, GSM_FRAME);
    collect(0, 0);
    total++;
    if (first_valid != LAT || got_n != int'(KSB)) begin
      bad++; $display("FAIL abort_restart: got lat %0d n %0d want %0d/%0d", first_valid, got_n, LAT, KSB);
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_bits[i] !== exp_bits[i]) begin
        bad++; $display("FAIL abort_bit%0d: got %b want %b", i, got_bits[i], exp_bits[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] k;
    logic [21:0] f;
    int n;
    ks_ready = 1'b1;
    start_session({$urandom, $urandom}, 22'($urandom));
    n = 0;
    while (ks_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (ks_valid !== 1'b1) begin
      bad++; $display("FAIL rst_reach_stream: got %b want 1 within 400 cycles", ks_valid);
    end
    repeat (20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if ({ks_valid, busy, done, ks_bit} !== 4'b0000) begin
      bad++; $display("FAIL rst_async: got %b want 0000", {ks_valid, busy, done, ks_bit});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_no_done: got %b want 0", done);
    end
    @(posedge clk); #1;
    k = {$urandom, $urandom};
    f = 22'($urandom);
    model_stream(k, f);
    start_session(k, f);
    collect(1, 0);
    total++;
    if (got_n != int'(KSB) || stall_err != 0 || done_count != 1) begin
      bad++; $display("FAIL rst_next_session: got n %0d stall %0d done %0d want %0d/0/1", got_n, stall_err, done_count, KSB);
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_bits[i] !== exp_bits[i]) begin
        bad++; $display("FAIL rst_bit%0d: got %b want %b", i, got_bits[i], exp_bits[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] k;
    logic [21:0] f;
    for (int s = 0; s < 2; s++) begin
      k = {$urandom, $urandom};
      f = 22'($urandom);
      model_stream(k, f);
      start_session(k, f);
      collect(s == 1, 0);
      total++;
      if (first_valid != LAT || got_n != int'(KSB) || done_cyc != last_hs + 1) begin
        bad++; $display("FAIL b2b%0d_timing: got lat %0d n %0d done %0d want %0d/%0d/%0d",
                        s, first_valid, got_n, done_cyc, LAT, KSB, last_hs + 1);
      end
      for (int i = 0; i < got_n; i++) begin
        total++;
        if (got_bits[i] !== exp_bits[i]) begin
          bad++; $display("FAIL b2b%0d_bit%0d: got %b want %b", s, i, got_bits[i], exp_bits[i]);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b1;
    key = '0; frame = '0;
    test_reset();
    test_gsm_vector();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
